// File: rtl/memory_write_arbiter.sv
// Round-robin arbiter sharing the memory unit write port among NREQ requesters.
// Each grant issues one single-cycle write, then a forced idle gap of GAP cycles.
module memory_write_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 35,
    parameter int GAP  = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               mem_wren,
    output logic [DW-1:0]      mem_din,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    // Counter only needs to hold GAP-1; keep at least one bit for GAP <= 1.
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_gap_cnt;
    logic [NREQ-1:0] r_ack;
    logic            r_wren;
    logic [DW-1:0]   r_din;
    logic [IDW-1:0]  r_grant_id;
    logic            r_busy;

    logic            w_found;
    logic [IDW-1:0]  w_sel;
    logic [IDW-1:0]  w_next_ptr;
    logic [DW-1:0]   w_sel_data;
    logic [NREQ-1:0] w_sel_onehot;

    // Index of the k-th requester in scan order starting at base.
    function automatic logic [IDW-1:0] rr_index(
        input logic [IDW-1:0] base,
        input int             k
    );
        int s;
        s = int'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Cyclic scan from the round-robin pointer for the first active request.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[rr_index(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = rr_index(r_rr_ptr, k);
            end
        end
    end

    // Pointer moves one past the winner, wrapping at the last requester.
    always_comb begin
        w_next_ptr = '0;
        if (w_sel != LAST_ID) begin
            w_next_ptr = w_sel + IDW'(1);
        end
    end

    // Record mux and one-hot acknowledge for the selected requester.
    always_comb begin
        w_sel_data   = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IDW'(i)) begin
                w_sel_data      = req_data[i*DW +: DW];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_gap_cnt  <= '0;
            r_ack      <= '0;
            r_wren     <= 1'b0;
            r_din      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_din      <= w_sel_data;
                        r_wren     <= 1'b1;
                        r_ack      <= w_sel_onehot;
                        r_grant_id <= w_sel;
                        r_rr_ptr   <= w_next_ptr;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wren <= 1'b0;
                    r_ack  <= '0;
                    if (GAP > 0) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_HOLD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - CW'(1);
                    end
                end
                default: begin
                    r_wren  <= 1'b0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign mem_wren = r_wren;
    assign mem_din  = r_din;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

    a_ack_onehot: assert property (
        @(posedge clk) disable iff (arst) $onehot0(r_ack)
    );

    a_ack_wren: assert property (
        @(posedge clk) disable iff (arst) ((|r_ack) == r_wren)
    );

endmodule

// File: tb/tb_memory_write_arbiter.sv
// Self-checking bench for memory_write_arbiter (GAP=2 and GAP=0 instances).
// Expected grants are queued when requests are raised and popped on each write.
module tb_memory_write_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 35;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } exp_t;

    logic               clk       = 1'b0;
    logic               arst      = 1'b1;
    logic [NREQ-1:0]    req       = '0;
    logic [NREQ-1:0]    req0      = '0;
    logic [NREQ*DW-1:0] req_data  = '0;
    logic [NREQ*DW-1:0] req_data0 = '0;

    logic [NREQ-1:0] ack, ack0;
    logic            mem_wren, mem_wren0;
    logic [DW-1:0]   mem_din, mem_din0;
    logic [IDW-1:0]  grant_id, grant_id0;
    logic            busy, busy0;

    always #5 clk = ~clk;

    memory_write_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DW(DW), .GAP(2)
    ) dut (
        .clk(clk), .arst(arst), .req(req), .req_data(req_data),
        .ack(ack), .mem_wren(mem_wren), .mem_din(mem_din),
        .grant_id(grant_id), .busy(busy)
    );

    memory_write_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DW(DW), .GAP(0)
    ) dut0 (
        .clk(clk), .arst(arst), .req(req0), .req_data(req_data0),
        .ack(ack0), .mem_wren(mem_wren0), .mem_din(mem_din0),
        .grant_id(grant_id0), .busy(busy0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int wr0_cnt  = 0;
    int last_wr_cyc  = 0;
    int last_wr0_cyc = 0;
    int gap_seen  = 0;
    int gap0_seen = 0;
    int low_run   = 0;
    int low_run0  = 0;
    int low_seen  = 0;
    int low0_seen = 0;
    bit wr_seen, wr0_seen;
    logic [NREQ-1:0] last_ack, last_ack0;
    logic [DW-1:0]   mem_model = '0;
    exp_t sb[$];
    exp_t sb0[$];

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] pat(input int i, input int s);
        logic [2:0] hi;
        hi = i[2:0] ^ s[2:0];
        return {hi, 32'hA500_0000 + 32'(s * 256 + i * 17)};
    endfunction

    task automatic set_data(input int s);
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW]  = pat(i, s);
            req_data0[i*DW +: DW] = pat(i, s + 100);
        end
    endtask

    task automatic expect_wr(input int id);
        exp_t e;
        e.id   = IDW'(id);
        e.data = req_data[id*DW +: DW];
        sb.push_back(e);
    endtask

    task automatic expect_wr0(input int id);
        exp_t e;
        e.id   = IDW'(id);
        e.data = req_data0[id*DW +: DW];
        sb0.push_back(e);
    endtask

    // One cycle: observe both DUTs at the falling edge, then model requesters
    // dropping req the cycle their ack is seen.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        wr_seen   = 1'b0;
        wr0_seen  = 1'b0;
        last_ack  = ack;
        last_ack0 = ack0;
        n_checks++;
        if (mem_wren === 1'b1) begin
            wr_seen = 1'b1;
            wr_cnt++;
            gap_seen    = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            low_seen    = low_run;
            low_run     = 0;
            mem_model   = mem_din;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got id=%0d din=%h ack=%b, required no write",
                         grant_id, mem_din, ack);
            end else begin
                e = sb.pop_front();
                if (ack !== onehot(e.id) || grant_id !== e.id ||
                    mem_din !== e.data || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write: got ack=%b id=%0d din=%h busy=%b, required ack=%b id=%0d din=%h busy=1",
                             ack, grant_id, mem_din, busy, onehot(e.id), e.id, e.data);
                end
            end
        end else begin
            if (busy === 1'b0) low_run++;
            if (ack !== '0 || mem_wren !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_without_write: got ack=%b wren=%b, required ack=0 wren=0",
                         ack, mem_wren);
            end
        end
        n_checks++;
        if (mem_wren0 === 1'b1) begin
            wr0_seen = 1'b1;
            wr0_cnt++;
            gap0_seen    = cyc - last_wr0_cyc;
            last_wr0_cyc = cyc;
            low0_seen    = low_run0;
            low_run0     = 0;
            if (sb0.size() == 0) begin
                n_fail++;
                $display("FAIL gap0_write_unexpected: got id=%0d din=%h, required no write",
                         grant_id0, mem_din0);
            end else begin
                e = sb0.pop_front();
                if (ack0 !== onehot(e.id) || grant_id0 !== e.id ||
                    mem_din0 !== e.data || busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap0_write: got ack=%b id=%0d din=%h, required ack=%b id=%0d din=%h",
                             ack0, grant_id0, mem_din0, onehot(e.id), e.id, e.data);
                end
            end
        end else begin
            if (busy0 === 1'b0) low_run0++;
            if (ack0 !== '0 || mem_wren0 !== 1'b0) begin
                n_fail++;
                $display("FAIL gap0_ack_without_write: got ack=%b wren=%b, required ack=0 wren=0",
                         ack0, mem_wren0);
            end
        end
        req  = req & ~ack;
        req0 = req0 & ~ack0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int b;
        b = 0;
        while (wr_cnt < target && b < budget) begin
            tick();
            b++;
        end
        n_checks++;
        if (wr_cnt < target) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d writes, required %0d", name, wr_cnt, target);
        end
    endtask

    task automatic check_empty(input string name);
        n_checks++;
        if (sb.size() != 0 || sb0.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d/%0d grants outstanding, required 0/0",
                     name, sb.size(), sb0.size());
        end
        sb.delete();
        sb0.delete();
    endtask

    task automatic do_reset();
        arst = 1'b1;
        req  = '0;
        req0 = '0;
        tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        set_data(1);
        arst = 1'b1;
        req  = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mem_wren !== 1'b0 || ack !== '0 || mem_din !== '0 ||
                busy !== 1'b0 || grant_id !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got wren=%b ack=%b din=%h busy=%b id=%0d, required all 0",
                         mem_wren, ack, mem_din, busy, grant_id);
            end
        end
        expect_wr(0);
        arst = 1'b0;
        tick();
        n_checks++;
        if (!wr_seen) begin
            n_fail++;
            $display("FAIL reset_first_grant: got wren=%b, required 1 one cycle after release",
                     mem_wren);
        end
        req = '0;
        drain(4);
        check_empty("reset");
    endtask

    task automatic test_single();
        int w0;
        w0 = wr_cnt;
        req_data[2*DW +: DW] = 35'h2A5A5A5A5;
        expect_wr(2);
        req = 4'b0100;
        wait_writes(w0 + 1, 10, "single");
        drain(6);
        n_checks++;
        if (wr_cnt != w0 + 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes, required 1", wr_cnt - w0);
        end
        n_checks++;
        if (grant_id !== 2'd2 || mem_din !== 35'h2A5A5A5A5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: got id=%0d din=%h busy=%b, required id=2 din=2a5a5a5a5 busy=0",
                     grant_id, mem_din, busy);
        end
        n_checks++;
        if (mem_model !== 35'h2A5A5A5A5) begin
            n_fail++;
            $display("FAIL single_mem: got dout=%h, required 2a5a5a5a5", mem_model);
        end
        check_empty("single");
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] rr;
        int w0;
        do_reset();
        set_data(2);
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) expect_wr(i % NREQ);
        req = '1;
        rr  = '0;
        for (int c = 0; c < 40 && wr_cnt < w0 + 5; c++) begin
            tick();
            if (wr_seen && wr_cnt > w0 + 1) begin
                n_checks++;
                if (gap_seen != 4) begin
                    n_fail++;
                    $display("FAIL rr_spacing: got %0d cycles, required 4", gap_seen);
                end
            end
            req = req | rr;
            rr  = last_ack;
        end
        req = '0;
        n_checks++;
        if (wr_cnt != w0 + 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d writes, required 5", wr_cnt - w0);
        end
        drain(5);
        check_empty("round_robin");
    endtask

    task automatic test_wrap();
        int w0;
        do_reset();
        set_data(3);
        w0 = wr_cnt;
        expect_wr(3);
        req = 4'b1000;
        wait_writes(w0 + 1, 10, "wrap_first");
        expect_wr(0);
        expect_wr(3);
        req = 4'b1001;
        wait_writes(w0 + 3, 20, "wrap");
        req = '0;
        drain(5);
        check_empty("wrap");
    endtask

    task automatic test_gap();
        int w0, w1, k, k0;
        logic rr, rr0;
        do_reset();
        set_data(4);
        w0 = wr_cnt;
        w1 = wr0_cnt;
        expect_wr(0);
        expect_wr0(0);
        req  = 4'b0001;
        req0 = 4'b0001;
        k    = 1;
        k0   = 1;
        rr   = 1'b0;
        rr0  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (wr_seen && wr_cnt > w0 + 1) begin
                n_checks++;
                if (gap_seen != 4 || low_seen != 1) begin
                    n_fail++;
                    $display("FAIL gap2_period: got period=%0d idle=%0d, required period=4 idle=1",
                             gap_seen, low_seen);
                end
            end
            if (wr0_seen && wr0_cnt > w1 + 1) begin
                n_checks++;
                if (gap0_seen != 2 || low0_seen != 1) begin
                    n_fail++;
                    $display("FAIL gap0_period: got period=%0d idle=%0d, required period=2 idle=1",
                             gap0_seen, low0_seen);
                end
            end
            if (rr) req[0] = 1'b1;
            if (rr0) req0[0] = 1'b1;
            rr = last_ack[0] && (k < 4);
            if (rr) begin
                k++;
                expect_wr(0);
            end
            rr0 = last_ack0[0] && (k0 < 6);
            if (rr0) begin
                k0++;
                expect_wr0(0);
            end
        end
        n_checks++;
        if (wr_cnt != w0 + 4 || wr0_cnt != w1 + 6) begin
            n_fail++;
            $display("FAIL gap_count: got %0d/%0d writes, required 4/6",
                     wr_cnt - w0, wr0_cnt - w1);
        end
        req  = '0;
        req0 = '0;
        drain(3);
        check_empty("gap");
    endtask

    task automatic test_hold_reset();
        int w0;
        do_reset();
        set_data(5);
        w0 = wr_cnt;
        expect_wr(1);
        req = 4'b0010;
        wait_writes(w0 + 1, 10, "hold_first");
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_busy: got busy=%b in second hold cycle, required 1", busy);
        end
        arst = 1'b1;
        tick();
        arst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || grant_id !== '0 || mem_din !== '0 || mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_reset_state: got busy=%b id=%0d din=%h wren=%b, required all 0",
                     busy, grant_id, mem_din, mem_wren);
        end
        expect_wr(0);
        expect_wr(3);
        req = 4'b1001;
        wait_writes(w0 + 3, 20, "hold_rr_ptr");
        req = '0;
        drain(5);
        check_empty("hold_reset");
    endtask

    task automatic test_withdrawal();
        int w0;
        set_data(6);
        w0 = wr_cnt;
        expect_wr(0);
        req = 4'b0001;
        wait_writes(w0 + 1, 10, "withdraw_first");
        tick();
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        drain(6);
        n_checks++;
        if (wr_cnt != w0 + 1) begin
            n_fail++;
            $display("FAIL withdraw_count: got %0d writes, required 1", wr_cnt - w0);
        end
        check_empty("withdrawal");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_gap();
        test_hold_reset();
        test_withdrawal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_write_arbiter.md
Name: memory_write_arbiter

Overview:
- Shares the single write port of the house memory unit (35-bit records, wren/din) among NREQ requesters, such as sensor loggers, the keypad event logger and the door controller.
- Uses round-robin arbitration with a req/ack handshake.
- Issues exactly one single-cycle write per grant.
- Enforces a minimum idle gap between consecutive writes.
- Sits between the requester modules and the memory unit's wren/din inputs.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, width of grant_id; must satisfy 2^IDW >= NREQ.
- DW, 35, record width; matches the memory unit din/dout.
- GAP, 2, number of forced idle cycles after each write cycle (0 allowed).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- arst, input, 1, reset; synchronous, active-high.
- req, input, NREQ, per-requester write request; level, held until ack.
- req_data, input, NREQ*DW, requester i record at bits [i*DW +: DW]; held stable while req[i] is high.
- ack, output, NREQ, one-cycle grant/acknowledge pulse per requester.
- mem_wren, output, 1, write enable to the memory unit.
- mem_din, output, DW, record to the memory unit.
- grant_id, output, IDW, index of the last granted requester.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Reset is sampled only on clk rising edges; arst high at an edge forces reset state that edge. At reset:
  - state = IDLE, rr_ptr = 0
  - mem_wren = 0, mem_din = 0, ack = 0, grant_id = 0, busy = 0
  - gap counter = 0
- All outputs are registered; there are no combinational paths from req to outputs.
- FSM states: IDLE, WRITE, HOLD.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select sel = first i with req[i]=1, scanning cyclically rr_ptr, rr_ptr+1, ..., wrapping NREQ-1 -> 0.
  - At that edge: mem_din <= req_data[sel], mem_wren <= 1, ack[sel] <= 1, grant_id <= sel, rr_ptr <= (sel+1) mod NREQ. Next state WRITE.
- WRITE (lasts exactly 1 cycle):
  - At the next edge: mem_wren <= 0, ack <= 0. mem_din and grant_id keep their values.
  - If GAP > 0: load counter = GAP-1 and go to HOLD. Otherwise go to IDLE.
- HOLD:
  - If counter == 0, go to IDLE; otherwise decrement.
  - HOLD lasts exactly GAP cycles. req is ignored in HOLD.
- Latency: req[i] sampled high at edge k while in IDLE -> mem_wren and ack[i] both high during cycle k..k+1.
- Minimum spacing between mem_wren pulses is GAP+2 cycles. The IDLE cycle is mandatory.
- ack and mem_wren are always coincident and exactly one cycle wide. At most one ack bit is high at any time.
- Requester contract:
  - Drop req by the edge after ack.
  - If req[i] is still high when IDLE is re-entered, it counts as a new request and competes normally.
- Withdrawal: a requester that drops req before being granted is simply not selected. No ack is issued and no state is changed.
- Fairness: under continuous requests from all requesters, grants rotate strictly 0,1,2,...,NREQ-1,0. No requester waits more than NREQ grants.
- Simultaneous events: several requests in the same IDLE cycle are resolved solely by rr_ptr. A request arriving during WRITE/HOLD waits for IDLE.
- Reset mid-operation: arst during WRITE or HOLD returns to reset values at that edge. A write already driven in WRITE completes its single cycle only if arst is low at its terminating edge; no second write is issued after reset.
- mem_din holds the last granted record while idle; it changes only on grant or reset.

Test Plan:
- Reset: arst=1 for 3 cycles with req=4'b1111 -> mem_wren=0, ack=0, mem_din=0, busy=0 throughout. Release arst -> first grant goes to requester 0 one cycle later.
- Single request: req=4'b0100, req_data[2]=35'h2A5A5A5A5 -> exactly one cycle with mem_wren=1, ack=4'b0100, mem_din=35'h2A5A5A5A5, grant_id=2. The memory unit's dout then reads 35'h2A5A5A5A5.
- Round-robin (GAP=2): req=4'b1111 held, each requester dropping req the cycle after its ack and re-raising it 1 cycle later -> grant_id sequence 0,1,2,3,0. mem_wren pulses exactly 4 cycles apart.
- Pointer wrap and priority: grant requester 3 first, then raise req=4'b1001 -> next grant goes to 0 (rr_ptr wrapped to 0), then to 3.
- Gap enforcement (GAP=0 and GAP=2 builds): continuous req=4'b0001 -> mem_wren period of 2 and 4 cycles respectively. busy is low for exactly 1 cycle between writes.
- Reset mid-HOLD and withdrawal: assert arst in the second HOLD cycle -> state IDLE with rr_ptr=0. Separately, pulse req[1] high for one cycle during HOLD -> no ack[1] and no write.
